// File: rtl/tbuf_port_arbiter.sv
// tbuf_port_arbiter: four-way token buffer port arbiter with burst lock, DRAM priority and read-return routing
module tbuf_port_arbiter #(
    parameter int DW        = 1024,
    parameter int AW        = 8,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_dram_prio,
    input  logic [3:0]      req,
    input  logic [3:0]      lock,
    input  logic [3:0]      we,
    input  logic [4*AW-1:0] addr,
    input  logic [4*DW-1:0] wdata,
    output logic [3:0]      gnt,
    output logic [3:0]      rvalid,
    output logic [DW-1:0]   rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    output logic [1:0]      src_sel,
    output logic            busy
);
    localparam int CW = $clog2(MAX_BURST + 1);

    logic [1:0]        ptr, owner, g, idx;
    logic              owner_v, gv, locked;
    logic [CW-1:0]     cnt;
    logic [RD_LAT-1:0] pv;
    logic [1:0]        ps [RD_LAT];

    assign locked = owner_v && req[owner] && lock[owner] && (cnt < CW'(MAX_BURST));
    assign gnt    = gv ? (4'b0001 << g) : 4'b0000;
    assign rvalid = pv[RD_LAT-1] ? (4'b0001 << ps[RD_LAT-1]) : 4'b0000;
    assign rdata  = mem_rdata;
    assign busy   = mem_en | (|pv);

    // pick the winner: locked owner, then DRAM priority, then round-robin from ptr
    always_comb begin
        g   = 2'd0;
        gv  = 1'b0;
        idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                g  = idx;
                gv = 1'b1;
            end
        end
        if (locked) begin
            g  = owner;
            gv = 1'b1;
        end else if (cfg_dram_prio && req[0]) begin
            g  = 2'd0;
            gv = 1'b1;
        end
        gv = gv && !rst;
    end

    // arbitration state, registered memory command and read-tag pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= 2'd0;
            owner     <= 2'd0;
            owner_v   <= 1'b0;
            cnt       <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            src_sel   <= 2'd0;
            pv        <= '0;
            for (int k = 0; k < RD_LAT; k++) ps[k] <= 2'd0;
        end else begin
            mem_en <= gv;
            pv[0]  <= mem_en && !mem_we;
            ps[0]  <= src_sel;
            for (int k = 1; k < RD_LAT; k++) begin
                pv[k] <= pv[k-1];
                ps[k] <= ps[k-1];
            end
            if (gv) begin
                ptr       <= g + 2'd1;
                owner_v   <= lock[g];
                owner     <= lock[g] ? g : 2'd0;
                cnt       <= lock[g] ? (locked ? cnt + 1'b1 : CW'(1)) : '0;
                mem_we    <= we[g];
                mem_addr  <= addr[g*AW +: AW];
                mem_wdata <= wdata[g*DW +: DW];
                src_sel   <= g;
            end
        end
    end
endmodule

// File: doc/tbuf_port_arbiter.md
Name: tbuf_port_arbiter

Overview:
- Shares the single-port token buffer between four requesters: 0=DRAM fill, 1=act dispatcher, 2=output collector, 3=gating module.
- Per cycle: arbitrates, registers one memory command, and tracks outstanding reads so read data goes back only to the issuing requester.
- Replaces the static src_sel mux driven by the main controller. Supports burst lock (DRAM fills, collector write-back) and a DRAM strict-priority mode.

Parameters:
- DW, 1024, data width of the token buffer word.
- AW, 8, address width.
- RD_LAT, 1, token buffer read latency in cycles (memory command to data), 1..4.
- MAX_BURST, 16, maximum consecutive grants to one locked requester before forced rotation.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- cfg_dram_prio  in  1  1=DRAM strict priority, 0=pure round-robin
- req  in  4  per-requester request, held until granted
- lock  in  4  per-requester burst lock, sampled with req
- we  in  4  per-requester write enable
- addr  in  4*AW  packed addresses, requester i at [i*AW +: AW]
- wdata  in  4*DW  packed write data
- gnt  out  4  one-hot grant, combinational, same cycle as req
- rvalid  out  4  one-hot read-data-valid
- rdata  out  DW  read data, broadcast, qualified by rvalid
- mem_en  out  1  registered memory enable
- mem_we  out  1  registered memory write enable
- mem_addr  out  AW  registered memory address
- mem_wdata  out  DW  registered memory write data
- mem_rdata  in  DW  memory read data, valid RD_LAT cycles after mem_en&!mem_we
- src_sel  out  2  registered index of the requester owning the current memory command
- busy  out  1  any read outstanding or mem_en high

Behaviour:
- Reset (rst=1 at a clk edge):
  - gnt, rvalid, mem_en, mem_we, busy = 0; mem_addr, mem_wdata, src_sel = 0.
  - RR pointer = 0, lock owner cleared, burst counter = 0, read-tag pipeline flushed.
  - rdata is don't-care.
  - Reset mid-burst or mid-read drops all in-flight reads; no rvalid after reset.
- Arbitration, evaluated combinationally each cycle:
  - Locked state active (owner valid, req[owner]=1, lock[owner]=1, burst count < MAX_BURST): gnt = owner.
  - Else if cfg_dram_prio=1 and req[0]: gnt = 0.
  - Else round-robin: first asserted req scanning from ptr upward, modulo 4.
  - At most one gnt bit is set; gnt = 0 when req = 0.
- State updates on a grant to index g:
  - ptr <= (g+1) mod 4.
  - If lock[g]=1: owner <= g; count <= count+1 if g already owned, else 1.
  - If lock[g]=0: owner cleared, count <= 0.
- Burst limit:
  - A locked owner whose count reaches MAX_BURST is released. That cycle it competes normally from ptr (owner+1), so others get a turn.
  - It may re-acquire the lock afterwards; count restarts at 1.
- Lock release:
  - Owner deasserting req or lock releases it that cycle; the grant goes to normal arbitration the same cycle, no bubble.
- Command register, next edge after gnt:
  - mem_en=|gnt, mem_we=we[g], mem_addr=addr[g], mem_wdata=wdata[g], src_sel=g.
  - When no grant: mem_en=0, and the other mem_* outputs hold their previous values.
- Read return:
  - A shift pipeline of depth RD_LAT carries {valid, src} for every read command.
  - rvalid[src] is asserted exactly RD_LAT cycles after mem_en for a read, i.e. RD_LAT+1 cycles after gnt; rdata = mem_rdata that cycle.
  - Writes produce no rvalid.
  - One read may issue per cycle: full throughput, no stall.
- Hazards:
  - Same-address write then read in consecutive cycles from different requesters returns the new data (memory order = grant order).
  - The arbiter does no reordering.
- Handshake error:
  - req[i] dropped before gnt[i] is legal (request withdrawn).
  - Changing addr/we/wdata while req is high without a grant is legal; only the values in the grant cycle are used.

Test Plan:
- Single read: req=4'b0010, addr[1]=8'h05, we=0, RD_LAT=1 → gnt=4'b0010 cycle 0; mem_en=1, mem_addr=8'h05, src_sel=1 cycle 1; rvalid=4'b0010 with rdata=mem[5] cycle 2.
- Round-robin fairness: req=4'b1111 held, no locks, cfg_dram_prio=0 → grant sequence 0,1,2,3,0,… for 8 cycles; every requester gets exactly 2 grants.
- DRAM priority: cfg_dram_prio=1, req=4'b1101 held → gnt=4'b0001 every cycle. Dropping req[0] → grants 2,3,2,3.
- Burst lock with limit: MAX_BURST=4, req[2]&lock[2] held, req[1] held → 4 grants to 2, then 1 grant to 1, then 4 to 2 again.
- Write/read ordering: requester 3 writes 0xAA to addr 10, requester 1 reads addr 10 in the next cycle → rvalid[1] with rdata=0xAA, rvalid[3] never set.
- Reset mid-read: RD_LAT=3, issue two reads, assert rst one cycle after the second gnt → all outputs 0 next cycle; no rvalid in the following 5 cycles; ptr restarts at 0.
